// File: rtl/serial_lane_pkg.sv
// Shared defaults and round-robin index helper for the serial lane arbiter.
// Pure definitions: no latency, no flow control.
package serial_lane_pkg;

  localparam int WORD_LEN_DEF = 33;
  localparam int NUM_REQ_DEF  = 4;
  localparam int SEL_W_DEF    = 2;

  // Next requester index in round-robin order, wrapping at n-1 to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/serial_lane_arbiter_rr_pick.sv
// Round-robin pick: first set req bit after last, wrapping; one-hot grant plus index.
// Purely combinational; grant is all-zero when no request is set.
module rr_pick
  import serial_lane_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = int'(last);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_next(cand, NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Arbitrates double words from NUM_REQ requesters onto one word lane, packet-locked; latency 1 cycle.
// Backpressure: dout held while dout_ready is low; req_ready only asserts when the store can take a new double word.
module serial_lane_arbiter
  import serial_lane_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*2*WORD_LEN-1:0] req_din,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_eop,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WORD_LEN-1:0]           dout,
  output logic [SEL_W-1:0]              dout_src,
  output logic                          dout_eop,
  output logic                          dout_valid,
  input  logic                          dout_ready
);

  localparam int DW = 2 * WORD_LEN;

  logic [1:0]         count;
  logic [DW-1:0]      store;
  logic [SEL_W-1:0]   src_q;
  logic               eop_q;
  logic               locked;
  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   sel_idx;
  logic               sel_vld;
  logic               load_cap;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // A locked packet only ever continues from its owner; nobody else may interleave.
  assign load_cap = (count == 2'd0) || ((count == 2'd1) && dout_ready);
  assign sel_idx  = locked ? owner : pick_idx;
  assign sel_vld  = locked ? req_valid[owner] : (|pick_grant);
  assign xfer     = rst_n && load_cap && sel_vld;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[sel_idx] = 1'b1;
  end

  assign dout       = store[WORD_LEN-1:0];
  assign dout_src   = src_q;
  assign dout_valid = rst_n && (count != 2'd0);
  assign dout_eop   = rst_n && (count == 2'd1) && eop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      store      <= '0;
      src_q      <= '0;
      eop_q      <= 1'b0;
      locked     <= 1'b0;
      owner      <= '0;
      last_grant <= SEL_W'(NUM_REQ - 1);
    end else if (xfer) begin
      store <= req_din[int'(sel_idx)*DW +: DW];
      count <= 2'd2;
      src_q <= sel_idx;
      eop_q <= req_eop[sel_idx];
      if (req_eop[sel_idx]) begin
        locked     <= 1'b0;
        last_grant <= sel_idx;
      end else begin
        locked <= 1'b1;
        owner  <= sel_idx;
      end
    end else if (dout_valid && dout_ready) begin
      store <= {{WORD_LEN{1'b0}}, store[DW-1:WORD_LEN]};
      count <= count - 2'd1;
    end
  end

endmodule
